// File: rtl/plic_claim_arbiter_pkg.sv
// rtl/plic_claim_arbiter_pkg.sv - shared constants and types for the PLIC claim arbiter
//
// Purpose : default sizing, register offsets of the per-target APB window,
//           and scalar types for priorities and claim/complete IDs.
// Ports   : none (package).
package plic_claim_arbiter_pkg;

    localparam int IRQ_NUM_DEF        = 32;
    localparam int IRQ_PRIO_WIDTH_DEF = 3;
    localparam int IRQ_ID_WIDTH_DEF   = $clog2(IRQ_NUM_DEF);

    // Register offsets within the PLIC address map.
    localparam logic [23:0] PLIC_OFS_IP        = 24'h00_1000;
    localparam logic [23:0] PLIC_OFS_IE        = 24'h00_2000;
    localparam logic [23:0] PLIC_OFS_THOLD     = 24'h20_0000;
    localparam logic [23:0] PLIC_OFS_CLAIMCOMP = 24'h20_0004;

    typedef logic [IRQ_PRIO_WIDTH_DEF-1:0] plic_prio_t;
    typedef logic [IRQ_ID_WIDTH_DEF-1:0]   plic_id_t;

endpackage

// File: rtl/plic_claim_arbiter_if.sv
// rtl/plic_claim_arbiter_if.sv - gateway handshake and claim/complete bus of the arbiter
//
// Purpose : bundles the per-source gateway handshake (valid/ready/comp pulse)
//           and the CLAIMCOMP register access strobes.
// Signals : valid_i, ready_o, comp_o       - gateway side, per source
//           claim_i, claim_id_o            - APB read of CLAIMCOMP
//           comp_i, comp_id_i              - APB write of CLAIMCOMP
//           Suffixes are from the arbiter's point of view.
interface plic_claim_arbiter_if
    import plic_claim_arbiter_pkg::*;
#(
    parameter int IRQ_NUM      = IRQ_NUM_DEF,
    parameter int IRQ_ID_WIDTH = $clog2(IRQ_NUM)
);
    logic [IRQ_NUM-1:0]      valid_i;
    logic [IRQ_NUM-1:0]      ready_o;
    logic [IRQ_NUM-1:0]      comp_o;
    logic                    claim_i;
    logic [IRQ_ID_WIDTH-1:0] claim_id_o;
    logic                    comp_i;
    logic [IRQ_ID_WIDTH-1:0] comp_id_i;

    // Gateways plus register file.
    modport master (
        output valid_i, claim_i, comp_i, comp_id_i,
        input  ready_o, claim_id_o, comp_o
    );

    // The arbiter core.
    modport slave (
        input  valid_i, claim_i, comp_i, comp_id_i,
        output ready_o, claim_id_o, comp_o
    );
endinterface

// File: rtl/plic_claim_arbiter_prio_tree.sv
// rtl/plic_claim_arbiter_prio_tree.sv - combinational max-priority comparator tree
//
// Purpose : picks the (priority, id) pair with the highest priority, ties
//           resolved to the lowest id. Non-candidates must be presented
//           with priority 0.
// Ports   : prio_i     in  IRQ_NUM*IRQ_PRIO_WIDTH  flattened masked priorities
//           win_id_o   out ID width                winning source id
//           win_prio_o out IRQ_PRIO_WIDTH          winning priority (0 = none)
module plic_claim_arbiter_prio_tree #(
    parameter int IRQ_NUM        = 32,
    parameter int IRQ_PRIO_WIDTH = 3,
    parameter int IRQ_ID_WIDTH   = $clog2(IRQ_NUM)
) (
    input  logic [IRQ_NUM*IRQ_PRIO_WIDTH-1:0] prio_i,
    output logic [IRQ_ID_WIDTH-1:0]           win_id_o,
    output logic [IRQ_PRIO_WIDTH-1:0]         win_prio_o
);
    localparam int LEAVES = 1 << IRQ_ID_WIDTH;

    // Heap-ordered tree: node k has children 2k and 2k+1, leaves at LEAVES..2*LEAVES-1.
    logic [IRQ_PRIO_WIDTH-1:0] node_prio [1:2*LEAVES-1];
    logic [IRQ_ID_WIDTH-1:0]   node_id   [1:2*LEAVES-1];

    always_comb begin
        for (int k = 1; k < 2*LEAVES; k++) begin
            node_prio[k] = '0;
            node_id[k]   = '0;
        end
        // Padding leaves beyond IRQ_NUM carry priority 0 and can never win
        // against a real candidate.
        for (int i = 0; i < LEAVES; i++) begin
            node_id[LEAVES+i] = IRQ_ID_WIDTH'(i);
            if (i < IRQ_NUM) begin
                node_prio[LEAVES+i] = prio_i[i*IRQ_PRIO_WIDTH +: IRQ_PRIO_WIDTH];
            end
        end
        // Children are always resolved before their parent (descending walk).
        for (int k = LEAVES - 1; k >= 1; k--) begin
            if ((node_prio[2*k+1] > node_prio[2*k]) ||
                ((node_prio[2*k+1] == node_prio[2*k]) && (node_id[2*k+1] < node_id[2*k]))) begin
                node_prio[k] = node_prio[2*k+1];
                node_id[k]   = node_id[2*k+1];
            end else begin
                node_prio[k] = node_prio[2*k];
                node_id[k]   = node_id[2*k];
            end
        end
    end

    assign win_id_o   = node_id[1];
    assign win_prio_o = node_prio[1];

endmodule

// File: rtl/plic_claim_arbiter.sv
// rtl/plic_claim_arbiter.sv - per-target PLIC pending/selection/claim/complete core
//
// Purpose : holds the IP bits, accepts gateway requests, selects the best
//           enabled pending source above threshold, drives irq_o and
//           sequences claim/complete.
// Ports   : clk_i, rst_i  clock, asynchronous active-high reset
//           bus           slave side of plic_claim_arbiter_if
//           prio_i        flattened per-source priorities
//           en_i          per-source enables
//           thold_i       target threshold
//           ip_o          pending bits
//           irq_o         external interrupt to hart
module plic_claim_arbiter
    import plic_claim_arbiter_pkg::*;
#(
    parameter int IRQ_NUM        = IRQ_NUM_DEF,
    parameter int IRQ_PRIO_WIDTH = IRQ_PRIO_WIDTH_DEF,
    parameter int IRQ_ID_WIDTH   = $clog2(IRQ_NUM)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    plic_claim_arbiter_if.slave               bus,
    input  logic [IRQ_NUM*IRQ_PRIO_WIDTH-1:0] prio_i,
    input  logic [IRQ_NUM-1:0]                en_i,
    input  logic [IRQ_PRIO_WIDTH-1:0]         thold_i,
    output logic [IRQ_NUM-1:0]                ip_o,
    output logic                              irq_o
);
    logic [IRQ_NUM-1:0]                ip_q, ip_d;
    logic [IRQ_NUM-1:0]                comp_q, comp_d;
    logic [IRQ_ID_WIDTH-1:0]           sel_id_q, sel_id_d;
    logic                              irq_q, irq_d;
    logic [IRQ_NUM*IRQ_PRIO_WIDTH-1:0] cand_prio;
    logic [IRQ_ID_WIDTH-1:0]           win_id;
    logic [IRQ_PRIO_WIDTH-1:0]         win_prio;

    // Source 0 is reserved and never accepts a request.
    assign bus.ready_o = {~ip_q[IRQ_NUM-1:1], 1'b0};

    // Next-state pending vector. The claim clear is applied after the
    // handshake set so a same-cycle request for the claimed source loses.
    always_comb begin
        ip_d    = ip_q | (bus.valid_i & bus.ready_o);
        ip_d[0] = 1'b0;
        if (bus.claim_i && (sel_id_q != '0)) begin
            ip_d[sel_id_q] = 1'b0;
        end
    end

    // Selection runs on ip_d so a claim in this cycle already removes its
    // source from the next winner (back-to-back claims get distinct IDs).
    always_comb begin
        cand_prio = '0;
        for (int i = 0; i < IRQ_NUM; i++) begin
            if ((i != 0) && ip_d[i] && en_i[i] &&
                (prio_i[i*IRQ_PRIO_WIDTH +: IRQ_PRIO_WIDTH] > thold_i)) begin
                cand_prio[i*IRQ_PRIO_WIDTH +: IRQ_PRIO_WIDTH] =
                    prio_i[i*IRQ_PRIO_WIDTH +: IRQ_PRIO_WIDTH];
            end
        end
    end

    plic_claim_arbiter_prio_tree #(
        .IRQ_NUM        (IRQ_NUM),
        .IRQ_PRIO_WIDTH (IRQ_PRIO_WIDTH),
        .IRQ_ID_WIDTH   (IRQ_ID_WIDTH)
    ) u_prio_tree (
        .prio_i     (cand_prio),
        .win_id_o   (win_id),
        .win_prio_o (win_prio)
    );

    // A winning priority of 0 means no candidate exists.
    always_comb begin
        sel_id_d = (win_prio != '0) ? win_id : '0;
        irq_d    = (sel_id_d != '0);
    end

    // Completion pulse: only for a valid, enabled, non-reserved ID.
    always_comb begin
        comp_d = '0;
        if (bus.comp_i && (bus.comp_id_i != '0) && (int'(bus.comp_id_i) < IRQ_NUM)) begin
            if (en_i[bus.comp_id_i]) begin
                comp_d[bus.comp_id_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ip_q     <= '0;
            sel_id_q <= '0;
            irq_q    <= 1'b0;
            comp_q   <= '0;
        end else begin
            ip_q     <= ip_d;
            sel_id_q <= sel_id_d;
            irq_q    <= irq_d;
            comp_q   <= comp_d;
        end
    end

    assign bus.claim_id_o = sel_id_q;
    assign bus.comp_o     = comp_q;
    assign ip_o           = ip_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_plic_claim_arbiter.sv
// tb/tb_plic_claim_arbiter.sv - scoreboard testbench for plic_claim_arbiter
module tb_plic_claim_arbiter;
    localparam int N  = 20;
    localparam int PW = 3;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] prio_a [N];
    logic [N*PW-1:0] prio_flat;
    logic [N-1:0]  en;
    logic [PW-1:0] thold;
    logic [N-1:0]  ip;
    logic          irq;

    int errors = 0;
    int checks = 0;

    logic [IW-1:0] claim_exp [$];
    logic [N-1:0]  comp_exp  [$];

    plic_claim_arbiter_if #(.IRQ_NUM(N), .IRQ_ID_WIDTH(IW)) bus ();

    plic_claim_arbiter #(
        .IRQ_NUM        (N),
        .IRQ_PRIO_WIDTH (PW),
        .IRQ_ID_WIDTH   (IW)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bus     (bus),
        .prio_i  (prio_flat),
        .en_i    (en),
        .thold_i (thold),
        .ip_o    (ip),
        .irq_o   (irq)
    );

    always #5 clk = ~clk;

    always_comb begin
        prio_flat = '0;
        for (int i = 0; i < N; i++) prio_flat[i*PW +: PW] = prio_a[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expectation whenever the DUT presents a claim ID or a completion pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.claim_i) begin
                if (claim_exp.size() == 0) begin
                    check("claim_unexpected", 32'(bus.claim_id_o), 32'hFFFF_FFFF);
                end else begin
                    check("claim_id", 32'(bus.claim_id_o), 32'(claim_exp.pop_front()));
                end
            end
            if (bus.comp_o != '0) begin
                if (comp_exp.size() == 0) begin
                    check("comp_unexpected", 32'(bus.comp_o), 32'h0);
                end else begin
                    check("comp_o", 32'(bus.comp_o), 32'(comp_exp.pop_front()));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) prio_a[i] = '0;
        en = '0; thold = '0;
        bus.valid_i = '0; bus.claim_i = 1'b0; bus.comp_i = 1'b0; bus.comp_id_i = '0;
        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_ip", 32'(ip), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_claim_id", 32'(bus.claim_id_o), 32'h0);
        check("rst_ready", 32'(bus.ready_o), 32'hFFFFE);

        // Asynchronous reset while a source is pending and a completion pulse is live
        prio_a[1] = 3'd1; en[1] = 1'b1; bus.valid_i[1] = 1'b1;
        step();
        bus.valid_i = '0;
        check("pre_rst_irq", 32'(irq), 32'h1);
        bus.comp_i = 1'b1; bus.comp_id_i = 5'd1;
        step();
        bus.comp_i = 1'b0;
        check("pre_rst_comp", 32'(bus.comp_o), 32'h2);
        #1 rst = 1'b1;
        #1;
        check("arst_ip", 32'(ip), 32'h0);
        check("arst_irq", 32'(irq), 32'h0);
        check("arst_comp", 32'(bus.comp_o), 32'h0);
        check("arst_claim_id", 32'(bus.claim_id_o), 32'h0);
        prio_a[1] = '0; en[1] = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        check("post_rst_comp", 32'(bus.comp_o), 32'h0);

        // Single source
        prio_a[3] = 3'd2; en[3] = 1'b1; thold = '0;
        bus.valid_i[3] = 1'b1;
        step();
        bus.valid_i = '0;
        check("single_ip", 32'(ip), 32'h8);
        check("single_irq", 32'(irq), 32'h1);
        check("single_ready", 32'(bus.ready_o), 32'hFFFF6);
        bus.claim_i = 1'b1; claim_exp.push_back(5'd3);
        step();
        bus.claim_i = 1'b0;
        check("single_ip_clr", 32'(ip), 32'h0);
        check("single_irq_clr", 32'(irq), 32'h0);

        // Priority order and tie to lowest ID
        prio_a[5] = 3'd4; prio_a[2] = 3'd4; prio_a[7] = 3'd1;
        en[2] = 1'b1; en[5] = 1'b1; en[7] = 1'b1;
        bus.valid_i = 20'h000A4;
        step();
        bus.valid_i = '0;
        check("multi_ip", 32'(ip), 32'hA4);
        bus.claim_i = 1'b1;
        claim_exp.push_back(5'd2); claim_exp.push_back(5'd5);
        claim_exp.push_back(5'd7); claim_exp.push_back(5'd0);
        step(); step(); step();
        check("multi_irq_after3", 32'(irq), 32'h0);
        step();
        bus.claim_i = 1'b0;
        check("multi_ip_clr", 32'(ip), 32'h0);

        // Threshold and enable
        prio_a[4] = 3'd3; en[4] = 1'b1; thold = 3'd3;
        bus.valid_i[4] = 1'b1;
        step();
        bus.valid_i = '0;
        check("thold_irq", 32'(irq), 32'h0);
        check("thold_ip", 32'(ip), 32'h10);
        bus.claim_i = 1'b1; claim_exp.push_back(5'd0);
        step();
        bus.claim_i = 1'b0;
        check("thold_claim0_ip", 32'(ip), 32'h10);
        thold = 3'd2;
        step();
        check("thold_lower_irq", 32'(irq), 32'h1);
        en[4] = 1'b0;
        step();
        check("dis_irq", 32'(irq), 32'h0);
        check("dis_ip", 32'(ip), 32'h10);

        // Completion
        en[4] = 1'b1;
        bus.comp_i = 1'b1; bus.comp_id_i = 5'd4; comp_exp.push_back(20'h10);
        step();
        bus.comp_i = 1'b0;
        step(); step();
        bus.comp_i = 1'b1; bus.comp_id_i = 5'd0;
        step();
        bus.comp_i = 1'b0;
        en[4] = 1'b0;
        bus.comp_i = 1'b1; bus.comp_id_i = 5'd4;
        step();
        bus.comp_i = 1'b0;
        bus.comp_i = 1'b1; bus.comp_id_i = 5'd25;
        step();
        bus.comp_i = 1'b0;
        step(); step();
        check("comp_keeps_ip", 32'(ip), 32'h10);
        en[4] = 1'b1; thold = '0;
        step();
        bus.claim_i = 1'b1; claim_exp.push_back(5'd4);
        step();
        bus.claim_i = 1'b0;
        check("src4_clr", 32'(ip), 32'h0);

        // Collision: request for the claimed source, plus a simultaneous completion
        prio_a[6] = 3'd5; en[6] = 1'b1;
        bus.valid_i[6] = 1'b1;
        step();
        check("coll_irq", 32'(irq), 32'h1);
        bus.claim_i = 1'b1; claim_exp.push_back(5'd6);
        bus.comp_i = 1'b1; bus.comp_id_i = 5'd6; comp_exp.push_back(20'h40);
        step();
        bus.claim_i = 1'b0; bus.comp_i = 1'b0; bus.valid_i = '0;
        check("coll_ip", 32'(ip), 32'h0);
        check("coll_irq_clr", 32'(irq), 32'h0);
        step(); step();

        // Priority-0 source and reserved source 0
        prio_a[9] = 3'd0; en[9] = 1'b1; en[0] = 1'b1; prio_a[0] = 3'd7;
        bus.valid_i[9] = 1'b1; bus.valid_i[0] = 1'b1;
        step();
        bus.valid_i = '0;
        check("p0_ip", 32'(ip), 32'h200);
        check("p0_irq", 32'(irq), 32'h0);
        bus.claim_i = 1'b1; claim_exp.push_back(5'd0);
        step();
        bus.claim_i = 1'b0;
        check("p0_ip_kept", 32'(ip), 32'h200);
        check("p0_irq_kept", 32'(irq), 32'h0);

        step(); step(); step();
        check("claim_exp_left", 32'(claim_exp.size()), 32'h0);
        check("comp_exp_left", 32'(comp_exp.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/plic_claim_arbiter.md
Name: plic_claim_arbiter

Overview:
- Per-target PLIC core that sits between the per-source gateways and the APB register file.
- Holds the interrupt-pending (IP) bits and accepts gateway requests.
- Selects the highest-priority enabled pending source above the target threshold, and drives the external interrupt line.
- Sequences claim (read of CLAIMCOMP) and complete (write of CLAIMCOMP), returning completion pulses to the gateways.

Parameters:
- IRQ_NUM, 32, number of sources including source 0. Source 0 is reserved, never pends and is never selected. Range 2..1024.
- IRQ_PRIO_WIDTH, 3, width of each source priority and of the threshold.
- IRQ_ID_WIDTH, $clog2(IRQ_NUM), width of claim/complete IDs.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- valid_i  in  IRQ_NUM  per-source request from gateway
- ready_o  out  IRQ_NUM  per-source accept to gateway
- prio_i  in  IRQ_NUM*IRQ_PRIO_WIDTH  flattened priorities; source i occupies bits [i*W +: W]
- en_i  in  IRQ_NUM  per-source enable (IE register)
- thold_i  in  IRQ_PRIO_WIDTH  target threshold
- claim_i  in  1  one-cycle pulse: APB read of CLAIMCOMP
- claim_id_o  out  IRQ_ID_WIDTH  ID returned to the read data path
- comp_i  in  1  one-cycle pulse: APB write of CLAIMCOMP
- comp_id_i  in  IRQ_ID_WIDTH  ID written
- comp_o  out  IRQ_NUM  one-hot completion pulse to gateways
- ip_o  out  IRQ_NUM  pending bits (IP register readback)
- irq_o  out  1  external interrupt to hart

Behaviour:
- Reset (async, rst_i=1): ip_q=0, sel_id_q=0, irq_o=0, comp_o=0.
  - Outputs return to reset values immediately, including mid-claim.
  - No pulse is pending after release.
- Handshake:
  - ready_o[i] = ~ip_q[i] for i≥1; ready_o[0] = 0.
  - valid_i[i] & ready_o[i] sets ip_q[i] on the next edge.
- Claim clear: claim_i with sel_id_q≠0 clears ip_q[sel_id_q] on the next edge.
  - If the same source handshakes in the same cycle, the clear wins.
- ip_o = ip_q.
- Selection:
  - The candidate set is ip_d & en_i & (prio > thold_i), taken on the next-state pending vector ip_d.
  - The winner is the highest priority; ties go to the lowest ID.
  - Priority 0 is never a candidate.
  - The result registers into sel_id_q; 0 if no candidate.
  - irq_o is registered and equals (winner≠0).
- Latency:
  - valid_i accepted in cycle N → ip_o, irq_o and sel_id_q updated in N+1.
  - A change to en_i, prio_i or thold_i in cycle N → reflected in N+1.
- Claim:
  - claim_id_o = sel_id_q, combinational, so it is valid in the claim_i cycle.
  - With sel_id_q=0: return 0 and no state change.
  - Back-to-back claims in N and N+1 return distinct IDs, because selection is computed on ip_d.
- Complete: comp_i in cycle N → comp_o[comp_id_i]=1 in N+1 only, but only if:
  - comp_id_i≠0,
  - comp_id_i<IRQ_NUM, and
  - en_i[comp_id_i]=1.
  - Otherwise the completion is silently ignored.
  - Completion does not touch ip_q.
- Simultaneous claim_i and comp_i: both are processed independently in the same cycle.
- Disabling a pending source removes it from selection but keeps its ip_q bit.

Decomposition:
- plic_pkg: IRQ_NUM/PRIO/ID width defaults, CLAIMCOMP/IP/IE/THOLD offset constants, and a typedef for priority and ID.
- Sub-module plic_prio_tree: a purely combinational binary comparator tree over (prio, id) pairs.
  - Parameterised on IRQ_NUM and IRQ_PRIO_WIDTH.
  - Each node prefers the higher priority, then the lower ID.
  - Instantiated once.

Test Plan:
- Reset/single source:
  - Apply rst_i mid-run → all outputs 0 asynchronously.
  - Then prio[3]=2, en[3]=1, thold=0, valid_i[3] pulse at N → ip_o=0x8, irq_o=1, claim_id_o=3 at N+1, ready_o[3]=0.
- Priority and tie:
  - prio[5]=4, prio[2]=4, prio[7]=1, all pending and enabled → claim returns 2, then 5, then 7 on back-to-back claims.
  - A fourth claim returns 0; irq_o=0 after the third claim.
- Threshold/enable:
  - Source 4 prio=3 pending: thold=3 → irq_o=0, claim=0.
  - Then thold=2 → irq_o=1 next cycle.
  - Then en[4]=0 → irq_o=0 with ip_o[4] still 1.
- Complete:
  - comp_id=4 with en[4]=1 → comp_o=0x10 for exactly one cycle.
  - comp_id=0 → no pulse.
  - comp_id=4 with en[4]=0 → no pulse.
  - comp_id≥IRQ_NUM → no pulse.
- Collision: valid_i[6] asserted in the same cycle as a claim returning 6 → ip_o[6]=0 afterwards.
- Priority-0 source pending and enabled → never selected; irq_o stays 0.
